// File: rtl/elevator_pkg.sv
// Shared types and limits for the SCAN elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    localparam int MAX_FLOORS = 64;

endpackage

// File: rtl/elevator_req_tracker.sv
// Pending-call bitmap with set/clear arbitration and SCAN look-ahead flags.
// Flags use the pending bits plus any call accepted this cycle.
module elevator_req_tracker
    import elevator_pkg::*;
#(
    parameter int FLOOR_COUNT = 16,
    parameter int FLOOR_W     = $clog2(FLOOR_COUNT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [FLOOR_W-1:0]     req_floor,
    input  logic [FLOOR_W-1:0]     floor,
    input  logic [FLOOR_W-1:0]     target,
    input  logic                   block_here,
    input  logic                   clear_en,
    input  logic [FLOOR_W-1:0]     clear_floor,
    input  logic                   clear_all,
    output logic [FLOOR_COUNT-1:0] pending,
    output logic                   here,
    output logic                   any_above,
    output logic                   any_below,
    output logic                   hit_target
);

    logic [FLOOR_COUNT-1:0] pending_reg;
    logic [FLOOR_COUNT-1:0] pending_next;
    logic [FLOOR_COUNT-1:0] set_mask;
    logic [FLOOR_COUNT-1:0] clr_mask;
    logic [FLOOR_COUNT-1:0] eff_mask;
    logic [FLOOR_COUNT-1:0] here_mask;
    logic [FLOOR_COUNT-1:0] above_mask;
    logic [FLOOR_COUNT-1:0] below_mask;
    logic [FLOOR_COUNT-1:0] target_mask;

    // Out-of-range request floors match no bit, so they are dropped here.
    genvar gi;
    for (gi = 0; gi < FLOOR_COUNT; gi++) begin : g_floor
        localparam logic [FLOOR_W-1:0] FLOOR_ID = FLOOR_W'(gi);
        assign set_mask[gi]    = req_valid && !clear_all && (req_floor == FLOOR_ID)
                                 && !(block_here && (floor == FLOOR_ID));
        assign clr_mask[gi]    = clear_all || (clear_en && (clear_floor == FLOOR_ID));
        assign here_mask[gi]   = (floor == FLOOR_ID);
        assign above_mask[gi]  = (FLOOR_ID > floor);
        assign below_mask[gi]  = (FLOOR_ID < floor);
        assign target_mask[gi] = (target == FLOOR_ID);
    end

    assign eff_mask     = pending_reg | set_mask;
    // Clear beats a simultaneous set: the door is opening at that floor.
    assign pending_next = eff_mask & ~clr_mask;

    assign here       = |(eff_mask & here_mask);
    assign any_above  = |(eff_mask & above_mask);
    assign any_below  = |(eff_mask & below_mask);
    assign hit_target = |(eff_mask & target_mask);
    assign pending    = pending_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN elevator controller: FSM, travel timer and door dwell timer.
// Optional emergency recall to floor 0 is built when ELEV_EMERGENCY_EN is defined.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int FLOOR_COUNT   = 16,
    parameter int FLOOR_W       = $clog2(FLOOR_COUNT),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [FLOOR_W-1:0]     req_floor,
`ifdef ELEV_EMERGENCY_EN
    input  logic                   emergency,
`endif
    output logic [FLOOR_W-1:0]     elevator_floor,
    output logic                   moving_up,
    output logic                   moving_down,
    output logic                   door_open,
    output logic                   arrived,
    output logic [FLOOR_COUNT-1:0] pending
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0]      DOOR_LAST   = DW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(FLOOR_COUNT - 1);

    state_t             state_reg, state_next, sel_state;
    dir_t               last_dir_reg, dir_next;
    logic [FLOOR_W-1:0] floor_reg, floor_next, target;
    logic [TW-1:0]      travel_reg, travel_next;
    logic [DW-1:0]      door_reg, door_next;
    logic               arrived_reg, arrived_next;
    logic               here, any_above, any_below, hit_target;
    logic               emerg, req_here;

`ifdef ELEV_EMERGENCY_EN
    assign emerg = emergency;
`else
    assign emerg = 1'b0;
`endif

    assign req_here = req_valid && (req_floor == floor_reg) && !emerg;

    always_comb begin
        target = floor_reg;
        if (state_reg == MOVE_UP) begin
            target = floor_reg + FLOOR_W'(1);
        end else if (state_reg == MOVE_DOWN) begin
            target = floor_reg - FLOOR_W'(1);
        end
    end

    elevator_req_tracker #(
        .FLOOR_COUNT (FLOOR_COUNT),
        .FLOOR_W     (FLOOR_W)
    ) u_tracker (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_floor   (req_floor),
        .floor       (floor_reg),
        .target      (target),
        .block_here  (state_reg == DOOR_OPEN),
        .clear_en    (arrived_next),
        .clear_floor (floor_next),
        .clear_all   (emerg),
        .pending     (pending),
        .here        (here),
        .any_above   (any_above),
        .any_below   (any_below),
        .hit_target  (hit_target)
    );

    // SCAN choice made from IDLE and at the end of every door dwell.
    always_comb begin
        sel_state = IDLE;
        if (emerg) begin
            sel_state = (floor_reg == '0) ? DOOR_OPEN : MOVE_DOWN;
        end else if (here) begin
            sel_state = DOOR_OPEN;
        end else if (any_above && any_below) begin
            sel_state = (last_dir_reg == DIR_UP) ? MOVE_UP : MOVE_DOWN;
        end else if (any_above) begin
            sel_state = MOVE_UP;
        end else if (any_below) begin
            sel_state = MOVE_DOWN;
        end
    end

    always_comb begin
        state_next  = state_reg;
        floor_next  = floor_reg;
        dir_next    = last_dir_reg;
        travel_next = '0;
        door_next   = '0;
        unique case (state_reg)
            IDLE: state_next = sel_state;
            MOVE_UP: begin
                if (travel_reg != TRAVEL_LAST) begin
                    travel_next = travel_reg + TW'(1);
                end else if (floor_reg == TOP_FLOOR) begin
                    state_next = emerg ? MOVE_DOWN : IDLE;
                end else begin
                    floor_next = target;
                    if (emerg) begin
                        state_next = MOVE_DOWN;
                    end else if (hit_target) begin
                        state_next = DOOR_OPEN;
                    end else if (!any_above) begin
                        state_next = IDLE;
                    end
                end
            end
            MOVE_DOWN: begin
                if (travel_reg != TRAVEL_LAST) begin
                    travel_next = travel_reg + TW'(1);
                end else if (floor_reg == '0) begin
                    state_next = emerg ? DOOR_OPEN : IDLE;
                end else begin
                    floor_next = target;
                    if (emerg) begin
                        if (target == '0) begin
                            state_next = DOOR_OPEN;
                        end
                    end else if (hit_target) begin
                        state_next = DOOR_OPEN;
                    end else if (!any_below) begin
                        state_next = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                // Emergency at floor 0 holds the door with the dwell timer parked.
                if (emerg && (floor_reg == '0)) begin
                    door_next = '0;
                end else if (req_here) begin
                    door_next = '0;
                end else if (door_reg != DOOR_LAST) begin
                    door_next = door_reg + DW'(1);
                end else begin
                    state_next = sel_state;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next == MOVE_UP) begin
            dir_next = DIR_UP;
        end else if (state_next == MOVE_DOWN) begin
            dir_next = DIR_DOWN;
        end
    end

    assign arrived_next = (state_next == DOOR_OPEN) && (state_reg != DOOR_OPEN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            floor_reg    <= '0;
            last_dir_reg <= DIR_UP;
            travel_reg   <= '0;
            door_reg     <= '0;
            arrived_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            floor_reg    <= floor_next;
            last_dir_reg <= dir_next;
            travel_reg   <= travel_next;
            door_reg     <= door_next;
            arrived_reg  <= arrived_next;
        end
    end

    assign elevator_floor = floor_reg;
    assign moving_up      = (state_reg == MOVE_UP);
    assign moving_down    = (state_reg == MOVE_DOWN);
    assign door_open      = (state_reg == DOOR_OPEN);
    assign arrived        = arrived_reg;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench for elevator_scan_ctrl: expected arrivals (floor, cycle) are queued
// by the stimulus and checked by a monitor on every arrived pulse.
module tb_elevator_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_floor;
    logic [3:0]  elevator_floor;
    logic        moving_up, moving_down, door_open, arrived;
    logic [15:0] pending;

    logic        req2_valid;
    logic [3:0]  req2_floor;
    logic [3:0]  floor2;
    logic        up2, down2, door2, arr2;
    logic [9:0]  pending2;
`ifdef ELEV_EMERGENCY_EN
    logic        emergency;
    logic        emergency2;
`endif

    always #5 clk = ~clk;

    elevator_scan_ctrl #(.FLOOR_COUNT(16), .TRAVEL_CYCLES(4), .DOOR_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
`ifdef ELEV_EMERGENCY_EN
        .emergency(emergency),
`endif
        .elevator_floor(elevator_floor), .moving_up(moving_up), .moving_down(moving_down),
        .door_open(door_open), .arrived(arrived), .pending(pending)
    );

    // Non-power-of-two car so that out-of-range floor numbers are representable.
    elevator_scan_ctrl #(.FLOOR_COUNT(10), .TRAVEL_CYCLES(4), .DOOR_CYCLES(8)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req2_valid), .req_floor(req2_floor),
`ifdef ELEV_EMERGENCY_EN
        .emergency(emergency2),
`endif
        .elevator_floor(floor2), .moving_up(up2), .moving_down(down2),
        .door_open(door2), .arrived(arr2), .pending(pending2)
    );

    typedef struct packed {
        int floor;
        int when;
    } arr_t;

    arr_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s = %0h (cyc %0d)", name, act, cyc);
        end
    endtask

    function automatic logic [23:0] st();
        return {elevator_floor, moving_up, moving_down, door_open, arrived, pending};
    endfunction

    function automatic logic [17:0] st2();
        return {floor2, up2, down2, door2, arr2, pending2};
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic issue(input int f);
        req_valid = 1'b1;
        req_floor = 4'(f);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic issue2(input int f);
        req2_valid = 1'b1;
        req2_floor = 4'(f);
        @(negedge clk);
        req2_valid = 1'b0;
    endtask

    task automatic push(input int f, input int w);
        arr_t e;
        e.floor = f;
        e.when  = w;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        arr_t e;
        if (!reset && arrived) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_arrival actual floor=%0d cyc=%0d required none",
                         elevator_floor, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("arrive_floor", 64'(elevator_floor), 64'(e.floor));
                chk("arrive_cycle", 64'(cyc), 64'(e.when));
            end
        end
    end

    initial begin : stim
        int c;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_floor  = '0;
        req2_valid = 1'b0;
        req2_floor = '0;
`ifdef ELEV_EMERGENCY_EN
        emergency  = 1'b0;
        emergency2 = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_state", 64'(st()), 64'(24'h0));
        reset = 1'b0;

        // Idle with no calls
        repeat (100) @(negedge clk);
        chk("idle_100", 64'(st()), 64'(24'h0));

        // Floor 0 -> 3
        c = cyc;
        push(3, c + 13);
        issue(3);
        chk("t2_move_start", 64'(st()), 64'({4'd0, 4'b1000, 16'h0008}));
        wait_cyc(c + 12);
        chk("t2_last_move", 64'(st()), 64'({4'd2, 4'b1000, 16'h0008}));
        wait_cyc(c + 13);
        chk("t2_arrive", 64'(st()), 64'({4'd3, 4'b0011, 16'h0000}));
        wait_cyc(c + 20);
        chk("t2_door_last", 64'(st()), 64'({4'd3, 4'b0010, 16'h0000}));
        wait_cyc(c + 21);
        chk("t2_idle", 64'(st()), 64'({4'd3, 4'b0000, 16'h0000}));

        // SCAN: heading to 9, calls 7 and 2 injected at floor 5
        c = cyc;
        issue(9);
        wait_cyc(c + 9);
        chk("t3_at5", 64'(st()), 64'({4'd5, 4'b1000, 16'h0200}));
        push(7, c + 17);
        push(9, c + 33);
        push(2, c + 69);
        issue(7);
        issue(2);
        wait_cyc(c + 12);
        chk("t3_pending3", 64'(st()), 64'({4'd5, 4'b1000, 16'h0284}));
        wait_cyc(c + 17);
        chk("t3_stop7", 64'(st()), 64'({4'd7, 4'b0011, 16'h0204}));
        wait_cyc(c + 25);
        chk("t3_resume_up", 64'(st()), 64'({4'd7, 4'b1000, 16'h0204}));
        wait_cyc(c + 33);
        chk("t3_stop9", 64'(st()), 64'({4'd9, 4'b0011, 16'h0004}));
        wait_cyc(c + 41);
        chk("t3_reverse", 64'(st()), 64'({4'd9, 4'b0100, 16'h0004}));
        wait_cyc(c + 69);
        chk("t3_stop2", 64'(st()), 64'({4'd2, 4'b0011, 16'h0000}));
        wait_cyc(c + 77);
        chk("t3_idle", 64'(st()), 64'({4'd2, 4'b0000, 16'h0000}));

        // Same-floor call: door opens next cycle; repeat call restarts dwell
        c = cyc;
        push(2, c + 1);
        issue(2);
        chk("t4_open_here", 64'(st()), 64'({4'd2, 4'b0011, 16'h0000}));
        wait_cyc(c + 4);
        issue(2);
        chk("t4_restart_nopend", 64'(st()), 64'({4'd2, 4'b0010, 16'h0000}));
        wait_cyc(c + 12);
        chk("t4_door_extended", 64'(st()), 64'({4'd2, 4'b0010, 16'h0000}));
        wait_cyc(c + 13);
        chk("t4_door_closed", 64'(st()), 64'({4'd2, 4'b0000, 16'h0000}));

        // Out-of-range floor on a 10-floor car, then the top valid floor
        issue2(12);
        chk("t4_range_12", 64'(st2()), 64'({4'd0, 4'b0000, 10'h000}));
        issue2(15);
        chk("t4_range_15", 64'(st2()), 64'({4'd0, 4'b0000, 10'h000}));
        issue2(9);
        chk("t4_top_floor", 64'(st2()), 64'({4'd0, 4'b1000, 10'h200}));

        // Reset mid-move at floor 4
        c = cyc;
        issue(10);
        wait_cyc(c + 10);
        chk("t5_at4", 64'(st()), 64'({4'd4, 4'b1000, 16'h0400}));
        reset = 1'b1;
        #1;
        chk("t5_reset_async", 64'(st()), 64'(24'h0));
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_calls_lost", 64'(st()), 64'(24'h0));

`ifdef ELEV_EMERGENCY_EN
        // Emergency while moving up at floor 6
        c = cyc;
        issue(12);
        issue(14);
        wait_cyc(c + 26);
        chk("t6_at6", 64'(st()), 64'({4'd6, 4'b1000, 16'h5000}));
        push(0, c + 57);
        emergency = 1'b1;
        wait_cyc(c + 28);
        chk("t6_flushed", 64'(st()), 64'({4'd6, 4'b1000, 16'h0000}));
        wait_cyc(c + 30);
        chk("t6_reversed", 64'(st()), 64'({4'd7, 4'b0100, 16'h0000}));
        wait_cyc(c + 60);
        issue(5);
        wait_cyc(c + 80);
        chk("t6_door_held", 64'(st()), 64'({4'd0, 4'b0010, 16'h0000}));
        emergency = 1'b0;
        wait_cyc(c + 88);
        chk("t6_released", 64'(st()), 64'({4'd0, 4'b0000, 16'h0000}));
`endif

        repeat (4) @(negedge clk);
        chk("arrivals_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
